// File: rtl/spmv_result_packer_if.sv
// Stream bundle for the SpMV result packer: row-count config, row results in, packed beats out.
interface spmv_result_packer_if;
   logic [31:0]  S_AXIS_CFG_tdata;
   logic         S_AXIS_CFG_tvalid;
   logic         S_AXIS_CFG_tready;
   logic [255:0] S_AXIS_IN_tdata;
   logic         S_AXIS_IN_tvalid;
   logic         S_AXIS_IN_tready;
   logic [511:0] M_AXIS_OUT_tdata;
   logic [63:0]  M_AXIS_OUT_tkeep;
   logic         M_AXIS_OUT_tlast;
   logic         M_AXIS_OUT_tvalid;
   logic         M_AXIS_OUT_tready;

   modport slave (
      input  S_AXIS_CFG_tdata, S_AXIS_CFG_tvalid,
      output S_AXIS_CFG_tready,
      input  S_AXIS_IN_tdata, S_AXIS_IN_tvalid,
      output S_AXIS_IN_tready,
      output M_AXIS_OUT_tdata, M_AXIS_OUT_tkeep, M_AXIS_OUT_tlast, M_AXIS_OUT_tvalid,
      input  M_AXIS_OUT_tready
   );

   modport master (
      output S_AXIS_CFG_tdata, S_AXIS_CFG_tvalid,
      input  S_AXIS_CFG_tready,
      output S_AXIS_IN_tdata, S_AXIS_IN_tvalid,
      input  S_AXIS_IN_tready,
      input  M_AXIS_OUT_tdata, M_AXIS_OUT_tkeep, M_AXIS_OUT_tlast, M_AXIS_OUT_tvalid,
      output M_AXIS_OUT_tready
   );
endinterface

// File: rtl/spmv_result_packer.sv
// Rounds/saturates Q128.128 row results to Q32.32 and packs eight per 512-bit beat with tlast per job.
module spmv_result_packer #(
   parameter int unsigned IN_FRAC  = 128,
   parameter int unsigned OUT_FRAC = 32
) (
   input  logic                clk,
   input  logic                rst,
   spmv_result_packer_if.slave bus,
   output logic                done,
   output logic [31:0]         sat_count
);
   localparam int unsigned IN_W   = 256;
   localparam int unsigned LANE_W = 64;
   localparam int unsigned OUT_W  = 512;
   localparam int unsigned KEEP_W = 64;
   localparam int unsigned CNT_W  = 32;
   localparam int unsigned SHIFT  = IN_FRAC - OUT_FRAC;
   localparam logic signed [IN_W:0] ROUND = {{IN_W{1'b0}}, 1'b1} << (SHIFT - 1);
   localparam logic [LANE_W-1:0] POS_MAX = {1'b0, {(LANE_W-1){1'b1}}};
   localparam logic [LANE_W-1:0] NEG_MIN = {1'b1, {(LANE_W-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t             state;
   logic [CNT_W-1:0]   rows_left;
   logic [2:0]         lane;
   logic [OUT_W-1:0]   pack;
   logic [OUT_W-1:0]   out_data;
   logic [KEEP_W-1:0]  out_keep;
   logic               out_last;
   logic               out_valid;
   logic               cfg_ready;

   logic signed [IN_W:0] sum_c;
   logic signed [IN_W:0] shifted_c;
   logic                 sat_pos_c;
   logic                 sat_neg_c;
   logic [LANE_W-1:0]    conv_c;
   logic [OUT_W-1:0]     pack_next_c;
   logic [KEEP_W-1:0]    keep_c;
   logic                 in_ready_c;
   logic                 in_fire_c;
   logic                 out_fire_c;
   logic                 cfg_fire_c;
   logic                 last_row_c;
   logic                 beat_c;

   // Round half toward +inf at 257 bits, then clamp to the signed 64-bit lane range.
   always_comb begin
      sum_c     = $signed({bus.S_AXIS_IN_tdata[IN_W-1], bus.S_AXIS_IN_tdata}) + ROUND;
      shifted_c = sum_c >>> SHIFT;
      sat_pos_c = !shifted_c[IN_W] && (|shifted_c[IN_W-1:LANE_W-1]);
      sat_neg_c = shifted_c[IN_W] && !(&shifted_c[IN_W-1:LANE_W-1]);
      conv_c    = shifted_c[LANE_W-1:0];
      if (sat_pos_c) conv_c = POS_MAX;
      if (sat_neg_c) conv_c = NEG_MIN;
   end

   always_comb begin
      in_ready_c  = (state == RUN) && (!out_valid || bus.M_AXIS_OUT_tready);
      in_fire_c   = bus.S_AXIS_IN_tvalid && in_ready_c;
      out_fire_c  = out_valid && bus.M_AXIS_OUT_tready;
      cfg_fire_c  = bus.S_AXIS_CFG_tvalid && cfg_ready;
      last_row_c  = (rows_left == CNT_W'(1));
      beat_c      = in_fire_c && ((lane == 3'd7) || last_row_c);
      pack_next_c = pack;
      pack_next_c[LANE_W*lane +: LANE_W] = conv_c;
      // ~lane == 7-lane, so this leaves 8*(lane+1) ones.
      keep_c      = {KEEP_W{1'b1}} >> {~lane, 3'b000};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         rows_left <= '0;
         lane      <= '0;
         pack      <= '0;
         out_data  <= '0;
         out_keep  <= '0;
         out_last  <= 1'b0;
         out_valid <= 1'b0;
         cfg_ready <= 1'b0;
         done      <= 1'b0;
         sat_count <= '0;
      end else begin
         done <= 1'b0;
         if (out_fire_c) out_valid <= 1'b0;
         case (state)
            IDLE: begin
               cfg_ready <= 1'b1;
               if (cfg_fire_c) begin
                  rows_left <= bus.S_AXIS_CFG_tdata;
                  lane      <= '0;
                  pack      <= '0;
                  sat_count <= '0;
                  if (bus.S_AXIS_CFG_tdata == '0) begin
                     done <= 1'b1;
                  end else begin
                     state     <= RUN;
                     cfg_ready <= 1'b0;
                  end
               end
            end
            RUN: begin
               if (in_fire_c) begin
                  rows_left <= rows_left - CNT_W'(1);
                  if ((sat_pos_c || sat_neg_c) && (sat_count != '1))
                     sat_count <= sat_count + CNT_W'(1);
                  if (beat_c) begin
                     out_data  <= pack_next_c;
                     out_keep  <= keep_c;
                     out_last  <= last_row_c;
                     out_valid <= 1'b1;
                     pack      <= '0;
                     lane      <= '0;
                     if (last_row_c) state <= DRAIN;
                  end else begin
                     pack <= pack_next_c;
                     lane <= lane + 3'd1;
                  end
               end
            end
            DRAIN: begin
               if (out_fire_c && out_last) begin
                  done      <= 1'b1;
                  state     <= IDLE;
                  cfg_ready <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.S_AXIS_CFG_tready = cfg_ready;
   assign bus.S_AXIS_IN_tready  = in_ready_c;
   assign bus.M_AXIS_OUT_tdata  = out_data;
   assign bus.M_AXIS_OUT_tkeep  = out_keep;
   assign bus.M_AXIS_OUT_tlast  = out_last;
   assign bus.M_AXIS_OUT_tvalid = out_valid;
endmodule
